// File: rtl/ysyx_22041211_mdu.sv
// ysyx_22041211_mdu
// Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU.
// The execute stage stalls on the valid/ready handshake until the result returns.
// Multiplies use shift-add and divides use restoring division, one bit per cycle.
// Divide-by-zero and signed overflow are resolved in a single cycle.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   request valid
//   in_ready   unit can accept a request (IDLE)
//   mdu_op     funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   src1       rs1 operand
//   src2       rs2 operand
//   flush      kill any in-flight operation
//   out_valid  result valid (DONE)
//   out_ready  consumer takes the result
//   result     operation result, held stable while out_valid waits
//   busy       unit is not IDLE
//
// Build option:
//   YSYX_22041211_MDU_FAST_MUL_EN  when defined, the multiply ops use a single
//   combinational multiplier at accept and complete in one cycle.

module ysyx_22041211_mdu #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          mdu_op,
    input  logic [DATA_LEN-1:0] src1,
    input  logic [DATA_LEN-1:0] src2,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] result,
    output logic                busy
);

    localparam int CNT_W = $clog2(DATA_LEN) + 1;
    localparam logic [DATA_LEN-1:0] MIN_INT = {1'b1, {(DATA_LEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]      counter;
    logic [2*DATA_LEN-1:0] acc;
    logic [DATA_LEN-1:0]   opnd;
    logic [1:0]            op_q;
    logic                  neg_q;
    logic                  rem_neg_q;
    logic [DATA_LEN-1:0]   result_q;

    logic                  accept;
    logic                  is_mul;
    logic                  s1_signed;
    logic                  s2_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic                  div_zero;
    logic                  div_ovf;
    logic                  special;
    logic [DATA_LEN-1:0]   a_mag;
    logic [DATA_LEN-1:0]   b_mag;
    logic [DATA_LEN-1:0]   special_res;

    logic [DATA_LEN:0]     mul_sum;
    logic [DATA_LEN:0]     div_tmp;
    logic [DATA_LEN:0]     div_diff;
    logic [2*DATA_LEN-1:0] mul_next;
    logic [2*DATA_LEN-1:0] div_next;
    logic [2*DATA_LEN-1:0] prod_fix;
    logic [DATA_LEN-1:0]   mul_res;
    logic [DATA_LEN-1:0]   div_quo;
    logic [DATA_LEN-1:0]   div_rem;
    logic [DATA_LEN-1:0]   div_res;
    logic [DATA_LEN-1:0]   final_res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = result_q;
    assign accept    = in_valid & in_ready & ~flush;

    // Request decode. Signed operands are turned into magnitudes so both
    // iterative engines only ever work on unsigned values; the recorded sign
    // bits are applied once the last iteration completes. MULHSU treats only
    // rs1 as signed. Divide-by-zero and MIN_INT/-1 skip iteration entirely.
    always_comb begin
        is_mul      = ~mdu_op[2];
        s1_signed   = mdu_op[2] ? ~mdu_op[0] : (mdu_op[1] ^ mdu_op[0]);
        s2_signed   = mdu_op[2] ? ~mdu_op[0] : (mdu_op[1:0] == 2'b01);
        a_neg       = s1_signed & src1[DATA_LEN-1];
        b_neg       = s2_signed & src2[DATA_LEN-1];
        a_mag       = a_neg ? (~src1 + 1'b1) : src1;
        b_mag       = b_neg ? (~src2 + 1'b1) : src2;
        div_zero    = (src2 == '0);
        div_ovf     = mdu_op[2] & ~mdu_op[0] & (src1 == MIN_INT) & (&src2);
        special     = ~is_mul & (div_zero | div_ovf);
        special_res = '0;
        if (div_zero) begin
            special_res = mdu_op[1] ? src1 : '1;
        end else if (div_ovf) begin
            special_res = mdu_op[1] ? '0 : MIN_INT;
        end
    end

`ifdef YSYX_22041211_MDU_FAST_MUL_EN
    logic signed [2*DATA_LEN+1:0] fast_prod;
    logic [DATA_LEN-1:0]          fast_res;

    // Single-cycle multiply: sign-extending both operands by one bit lets one
    // signed multiplier cover the signed, unsigned and mixed variants.
    always_comb begin
        fast_prod = $signed({s1_signed & src1[DATA_LEN-1], src1})
                  * $signed({s2_signed & src2[DATA_LEN-1], src2});
        fast_res  = (mdu_op[1:0] == 2'b00) ? fast_prod[DATA_LEN-1:0]
                                           : fast_prod[2*DATA_LEN-1:DATA_LEN];
    end
`endif

    // One iteration step of each engine, both sharing the double-width
    // accumulator. Multiply: upper half accumulates the multiplicand when the
    // current multiplier bit is set, then everything shifts right. Divide: the
    // partial remainder in the upper half shifts in the next dividend bit and
    // the divisor is subtracted whenever it fits, shifting a quotient bit in.
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_LEN-1:DATA_LEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[DATA_LEN-1:1]};
        div_tmp  = {acc[2*DATA_LEN-1:DATA_LEN], acc[DATA_LEN-1]};
        div_diff = div_tmp - {1'b0, opnd};
        div_next = div_diff[DATA_LEN] ? {div_tmp[DATA_LEN-1:0], acc[DATA_LEN-2:0], 1'b0}
                                      : {div_diff[DATA_LEN-1:0], acc[DATA_LEN-2:0], 1'b1};
    end

    // Sign fix-up on the final step. The quotient takes the xor of the operand
    // signs while the remainder follows the dividend (truncating division).
    always_comb begin
        prod_fix  = neg_q ? (~mul_next + 1'b1) : mul_next;
        mul_res   = (op_q == 2'b00) ? prod_fix[DATA_LEN-1:0]
                                    : prod_fix[2*DATA_LEN-1:DATA_LEN];
        div_quo   = div_next[DATA_LEN-1:0];
        div_rem   = div_next[2*DATA_LEN-1:DATA_LEN];
        div_res   = op_q[1] ? (rem_neg_q ? (~div_rem + 1'b1) : div_rem)
                            : (neg_q ? (~div_quo + 1'b1) : div_quo);
        final_res = (state == MUL) ? mul_res : div_res;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE never accepts a new request even when the result
    // is consumed that cycle, so back-to-back ops always see one IDLE cycle.
    // A flush overrides everything and returns the unit to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
`ifdef YSYX_22041211_MDU_FAST_MUL_EN
                        state_next = DONE;
`else
                        state_next = MUL;
`endif
                    end else if (special) begin
                        state_next = DONE;
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (counter == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Datapath registers. Accept captures the operand magnitudes and result
    // signs and loads the iteration counter; each compute cycle advances the
    // active engine, and the signed-corrected result is written on the last
    // step. The result register is otherwise left untouched so it stays
    // stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter   <= '0;
            acc       <= '0;
            opnd      <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= mdu_op[1:0];
                        counter   <= CNT_W'(DATA_LEN - 1);
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        if (is_mul) begin
                            opnd <= a_mag;
                            acc  <= {{DATA_LEN{1'b0}}, b_mag};
`ifdef YSYX_22041211_MDU_FAST_MUL_EN
                            result_q <= fast_res;
`endif
                        end else begin
                            opnd <= b_mag;
                            acc  <= {{DATA_LEN{1'b0}}, a_mag};
                            if (special) begin
                                result_q <= special_res;
                            end
                        end
                    end
                end
                MUL, DIV: begin
                    acc     <= (state == MUL) ? mul_next : div_next;
                    counter <= counter - 1'b1;
                    if (counter == '0) begin
                        result_q <= final_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
